// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared CPU definitions for the fetch stage
package cpu_defs;
  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = '0;
  localparam logic [INST_W-1:0] RESET_PC = '0;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  typedef enum logic [1:0] {BOOT, RUN, HOLD} fetch_state_t;
  function automatic logic [5:0] opcode(input logic [INST_W-1:0] inst);
    return inst[OPC_MSB:OPC_LSB];
  endfunction
endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: control, ROM and IF/ID signals of the fetch stage
interface inst_fetch_if;
  import cpu_defs::*;
  logic              stall;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic [31:0]       rom_addr;
  logic [INST_W-1:0] rom_inst;
  logic [INST_W-1:0] id_inst;
  logic [31:0]       id_pc;
  logic [31:0]       id_pc_plus4;
  logic              id_valid;
  logic [31:0]       fetch_count;
  modport master (
    input  stall, redirect, redirect_pc, rom_inst,
    output rom_addr, id_inst, id_pc, id_pc_plus4, id_valid, fetch_count
  );
  modport slave (
    output stall, redirect, redirect_pc, rom_inst,
    input  rom_addr, id_inst, id_pc, id_pc_plus4, id_valid, fetch_count
  );
endinterface

// File: rtl/inst_fetch_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load and flush (bubble) controls
module if_id_reg #(
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_inst     <= NOP_INST;
      id_pc       <= '0;
      id_pc_plus4 <= '0;
      id_valid    <= 1'b0;
    end else if (flush) begin
      id_inst  <= NOP_INST;
      id_valid <= 1'b0;
    end else if (load) begin
      id_inst     <= inst;
      id_pc       <= pc;
      id_pc_plus4 <= pc + 32'd4;
      id_valid    <= 1'b1;
    end
  end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC, next-PC selection, fetch FSM and delivered-instruction counter
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input logic clk,
  input logic rst,
  inst_fetch_if.master bus
);
  import cpu_defs::*;
  fetch_state_t state, state_nx;
  logic [31:0] pc, pc_nx, count;
  logic [31:0] id_inst, id_pc, id_pc_plus4;
  logic        id_valid, adv;
  // redirect outranks stall; BOOT always moves on to RUN without capturing
  always_comb begin
    adv      = state != BOOT && !bus.stall && !bus.redirect;
    state_nx = (bus.redirect || state == BOOT || !bus.stall) ? RUN : HOLD;
    pc_nx    = bus.redirect ? {bus.redirect_pc[31:2], 2'b00} : adv ? pc + 32'd4 : pc;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
      pc    <= RESET_PC;
      count <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      if (adv) count <= count + 32'd1;
    end
  end
  if_id_reg #(.NOP_INST(NOP_INST)) u_if_id (
    .clk(clk), .rst(rst), .load(adv), .flush(bus.redirect),
    .inst(bus.rom_inst), .pc(pc),
    .id_inst(id_inst), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_valid(id_valid)
  );
  assign bus.rom_addr    = {pc[31:2], 2'b00};
  assign bus.id_inst     = id_inst;
  assign bus.id_pc       = id_pc;
  assign bus.id_pc_plus4 = id_pc_plus4;
  assign bus.id_valid    = id_valid;
  assign bus.fetch_count = count;
endmodule
